counter_scheduler: RTL and testbench

Round-robin scheduler that time-shares one delay counter among NUM_REQ requesters. Each requester raises a request with its own delay value. The block grants one requester at a time, counts the granted delay, and returns a one-cycle done pulse. It sits between the protocol/sequencing FSMs that need wait periods and the single counting resource, so the design instantiates one counter instead of one per client.

---
 rtl/counter_scheduler_pkg.sv | 18 +
 rtl/counter_scheduler_if.sv | 29 ++
 rtl/counter_scheduler_rr_arbiter.sv | 31 +++
 rtl/counter_scheduler.sv | 112 +++++++++++
 tb/tb_counter_scheduler.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/counter_scheduler_pkg.sv
// Shared types and width helpers for the counter scheduler slice.
package counter_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic int cw_f(input int max_delay);
    return $clog2(max_delay + 1);
  endfunction

  function automatic int idx_w_f(input int num_req);
    return (num_req < 2) ? 1 : $clog2(num_req);
  endfunction

endpackage

// File: rtl/counter_scheduler_if.sv
// Requester-side bundle of the shared delay counter: requests, delays and status.
interface counter_scheduler_if #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_DELAY = 2000
);
  import counter_scheduler_pkg::*;

  localparam int CW = cw_f(MAX_DELAY);
  localparam int IW = idx_w_f(NUM_REQ);

  logic [NUM_REQ-1:0]    req_i;
  logic [NUM_REQ*CW-1:0] delay_i;
  logic [NUM_REQ-1:0]    grant_o;
  logic [NUM_REQ-1:0]    done_o;
  logic                  busy_o;
  logic [IW-1:0]         active_id_o;
  logic [CW-1:0]         count_o;

  modport master (
    output req_i, delay_i,
    input  grant_o, done_o, busy_o, active_id_o, count_o
  );

  modport slave (
    input  req_i, delay_i,
    output grant_o, done_o, busy_o, active_id_o, count_o
  );

endinterface

// File: rtl/counter_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_arbiter
  import counter_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IW      = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      idx,
  output logic               vld
);

  always_comb begin
    int k;
    grant = '0;
    idx   = '0;
    vld   = 1'b0;
    k     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = (int'(ptr) + i) % NUM_REQ;
      if (!vld && req[IW'(k)]) begin
        vld            = 1'b1;
        idx            = IW'(k);
        grant[IW'(k)]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/counter_scheduler.sv
// Time-shares one delay counter among NUM_REQ requesters with round-robin grants
// and a one-cycle done pulse per completed delay.
module counter_scheduler
  import counter_scheduler_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int MAX_DELAY = 2000
) (
  input  logic               clock_i,
  input  logic               reset_i,
  counter_scheduler_if.slave bus
);

  localparam int CW = cw_f(MAX_DELAY);
  localparam int IW = idx_w_f(NUM_REQ);
  localparam logic [CW-1:0] MAX_D   = CW'(MAX_DELAY);
  localparam logic [IW-1:0] LAST_ID = IW'(NUM_REQ - 1);

  function automatic logic [CW-1:0] clamp_delay(input logic [CW-1:0] v);
    return (v > MAX_D) ? MAX_D : v;
  endfunction

  state_e             state_q, state_nxt;
  logic [IW-1:0]      ptr_q, id_q, arb_idx;
  logic [NUM_REQ-1:0] arb_onehot, grant_q, done_q;
  logic               arb_vld, busy_q;
  logic [CW-1:0]      d_q, count_q, sel_delay;
  logic               load, cnt_inc, cnt_clr, win_req;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (
    .req   (bus.req_i),
    .ptr   (ptr_q),
    .grant (arb_onehot),
    .idx   (arb_idx),
    .vld   (arb_vld)
  );

  always_comb begin
    sel_delay = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_idx == IW'(i)) sel_delay = bus.delay_i[i*CW +: CW];
    end
  end

  // Only the granted requester's level matters once counting has started.
  assign win_req = |(grant_q & bus.req_i);

  always_comb begin
    state_nxt = state_q;
    load      = 1'b0;
    cnt_inc   = 1'b0;
    cnt_clr   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arb_vld) begin
          state_nxt = ST_COUNT;
          load      = 1'b1;
        end
      end
      ST_COUNT: begin
        if (!win_req) begin
          state_nxt = ST_IDLE;
          cnt_clr   = 1'b1;
        end else if (count_q == d_q) begin
          state_nxt = ST_DONE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
        cnt_clr   = 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      d_q     <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_nxt;
      busy_q  <= (state_nxt != ST_IDLE);
      done_q  <= (state_nxt == ST_DONE) ? grant_q : '0;
      if (load) begin
        grant_q <= arb_onehot;
        id_q    <= arb_idx;
        d_q     <= clamp_delay(sel_delay);
        ptr_q   <= (arb_idx == LAST_ID) ? '0 : arb_idx + 1'b1;
      end else if (state_nxt == ST_IDLE) begin
        grant_q <= '0;
        id_q    <= '0;
      end
      if (load || cnt_clr) count_q <= '0;
      else if (cnt_inc)    count_q <= count_q + 1'b1;
    end
  end

  assign bus.grant_o     = grant_q;
  assign bus.done_o      = done_q;
  assign bus.busy_o      = busy_q;
  assign bus.active_id_o = id_q;
  assign bus.count_o     = count_q;

endmodule

// File: tb/tb_counter_scheduler.sv
// Directed bench for counter_scheduler: single request, round-robin order,
// re-request fairness, delay edge cases, abort and asynchronous reset.
module tb_counter_scheduler;
  import counter_scheduler_pkg::*;

  localparam int NUM_REQ   = 4;
  localparam int MAX_DELAY = 2000;
  localparam int CW        = cw_f(MAX_DELAY);

  logic          clock_i = 1'b0;
  logic          reset_i = 1'b1;
  logic [CW-1:0] dly [NUM_REQ];
  int            n_checks = 0;
  int            n_errors = 0;

  counter_scheduler_if #(.NUM_REQ(NUM_REQ), .MAX_DELAY(MAX_DELAY)) bus ();

  assign bus.delay_i = {dly[3], dly[2], dly[1], dly[0]};

  counter_scheduler #(.NUM_REQ(NUM_REQ), .MAX_DELAY(MAX_DELAY)) dut (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .bus     (bus)
  );

  always #5 clock_i = ~clock_i;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic apply_reset();
    reset_i    = 1'b1;
    bus.req_i  = '0;
    repeat (2) @(negedge clock_i);
    reset_i    = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, output int cyc);
    cyc = 0;
    while (bus.done_o == '0 && cyc < max_cyc) begin
      @(negedge clock_i);
      cyc++;
    end
    check("done_seen", int'(bus.done_o != '0), 1);
  endtask

  initial begin
    int nd, last, cyc;
    bus.req_i = '0;
    for (int k = 0; k < NUM_REQ; k++) dly[k] = '0;

    // reset state
    @(negedge clock_i);
    check("rst_grant", int'(bus.grant_o), 0);
    check("rst_done",  int'(bus.done_o), 0);
    check("rst_busy",  int'(bus.busy_o), 0);
    check("rst_id",    int'(bus.active_id_o), 0);
    check("rst_count", int'(bus.count_o), 0);
    reset_i = 1'b0;

    // single request, delay 5
    dly[0] = CW'(5);
    bus.req_i = 4'b0001;
    @(negedge clock_i);
    check("t1_grant", int'(bus.grant_o), 1);
    check("t1_busy",  int'(bus.busy_o), 1);
    check("t1_count0", int'(bus.count_o), 0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock_i);
      check("t1_count", int'(bus.count_o), k);
      check("t1_nodone", int'(bus.done_o), 0);
    end
    @(negedge clock_i);
    check("t1_done",  int'(bus.done_o), 1);
    check("t1_dgrant", int'(bus.grant_o), 1);
    bus.req_i = '0;
    @(negedge clock_i);
    check("t1_done_off", int'(bus.done_o), 0);
    check("t1_busy_off", int'(bus.busy_o), 0);
    check("t1_grant_off", int'(bus.grant_o), 0);

    // all four request together, delay 2 each
    apply_reset();
    for (int k = 0; k < NUM_REQ; k++) dly[k] = CW'(2);
    bus.req_i = 4'b1111;
    nd = 0;
    last = 0;
    for (int c = 1; c <= 60 && nd < 4; c++) begin
      @(negedge clock_i);
      if (c == 1) check("rr_first_grant", int'(bus.grant_o), 1);
      if (bus.done_o != '0) begin
        check("rr_order", int'(bus.done_o), 1 << nd);
        if (nd > 0) check("rr_spacing", c - last, 5);
        last = c;
        nd++;
        bus.req_i = bus.req_i & ~bus.done_o;
      end
    end
    check("rr_num_done", nd, 4);
    bus.req_i = '0;

    // requester 2 re-requests while 3 waits
    apply_reset();
    for (int k = 0; k < NUM_REQ; k++) dly[k] = CW'(1);
    bus.req_i = 4'b1100;
    wait_done(20, cyc);
    check("fair_first", int'(bus.done_o), 4);
    @(negedge clock_i);
    check("fair_idle", int'(bus.grant_o), 0);
    @(negedge clock_i);
    check("fair_next", int'(bus.grant_o), 8);
    check("fair_id", int'(bus.active_id_o), 3);
    wait_done(20, cyc);
    check("fair_done3", int'(bus.done_o), 8);
    bus.req_i = 4'b0100;
    @(negedge clock_i);
    @(negedge clock_i);
    check("fair_then2", int'(bus.grant_o), 4);
    wait_done(20, cyc);
    bus.req_i = '0;
    repeat (2) @(negedge clock_i);

    // delay 0, then all-ones delay (4095 truncated to CW bits) clamped to MAX_DELAY
    apply_reset();
    dly[0] = '0;
    bus.req_i = 4'b0001;
    @(negedge clock_i);
    check("d0_grant", int'(bus.grant_o), 1);
    check("d0_nodone", int'(bus.done_o), 0);
    @(negedge clock_i);
    check("d0_done", int'(bus.done_o), 1);
    bus.req_i = '0;
    @(negedge clock_i);
    check("d0_idle", int'(bus.busy_o), 0);
    dly[1] = '1;
    bus.req_i = 4'b0010;
    @(negedge clock_i);
    check("clamp_grant", int'(bus.grant_o), 2);
    wait_done(2100, cyc);
    check("clamp_latency", cyc, MAX_DELAY + 1);
    check("clamp_count", int'(bus.count_o), MAX_DELAY);
    bus.req_i = '0;
    repeat (2) @(negedge clock_i);

    // abort at count 3, pending requester 3 takes over
    apply_reset();
    dly[0] = CW'(10);
    dly[3] = CW'(2);
    bus.req_i = 4'b1001;
    @(negedge clock_i);
    check("ab_grant", int'(bus.grant_o), 1);
    repeat (3) @(negedge clock_i);
    check("ab_count3", int'(bus.count_o), 3);
    bus.req_i = 4'b1000;
    @(negedge clock_i);
    check("ab_grant_off", int'(bus.grant_o), 0);
    check("ab_busy_off", int'(bus.busy_o), 0);
    check("ab_count_clr", int'(bus.count_o), 0);
    check("ab_nodone", int'(bus.done_o), 0);
    @(negedge clock_i);
    check("ab_next_grant", int'(bus.grant_o), 8);
    check("ab_next_id", int'(bus.active_id_o), 3);
    wait_done(20, cyc);
    check("ab_done3", int'(bus.done_o), 8);
    bus.req_i = '0;
    repeat (2) @(negedge clock_i);

    // asynchronous reset between clock edges mid-count
    apply_reset();
    dly[0] = CW'(10);
    bus.req_i = 4'b0001;
    repeat (5) @(negedge clock_i);
    check("ar_pre_count", int'(bus.count_o), 4);
    #2 reset_i = 1'b1;
    #1;
    check("ar_grant", int'(bus.grant_o), 0);
    check("ar_done",  int'(bus.done_o), 0);
    check("ar_busy",  int'(bus.busy_o), 0);
    check("ar_id",    int'(bus.active_id_o), 0);
    check("ar_count", int'(bus.count_o), 0);
    bus.req_i = 4'b1001;
    @(negedge clock_i);
    reset_i = 1'b0;
    @(negedge clock_i);
    check("ar_prio_grant", int'(bus.grant_o), 1);
    check("ar_prio_id", int'(bus.active_id_o), 0);
    bus.req_i = '0;
    repeat (2) @(negedge clock_i);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
